mc_table_loader: RTL and testbench

Streaming table loader feeding one MCCore instance (or a lock-stepped group of instances) with sigma and mu coefficient tables. It accepts 18-bit words on a valid/ready stream and writes them, in order, into the core's buffer-bank sigma RAM and then its mu RAM. When both tables are complete and the core has finished its current run, it swaps the RAM banks and issues a one-cycle start pulse. Loading of the next tables then overlaps with the core's computation on the freshly swapped bank.

---
 rtl/mc_table_loader.sv | 138 +++++++++++++
 tb/tb_mc_table_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_table_loader.sv
// Streams sigma then mu coefficient words into an MCCore buffer bank. It then swaps banks and pulses start once the core is idle.
// Writes land one cycle after acceptance. oReady drops from the last mu word until the start pulse.
module mc_table_loader #(
    parameter int pathWidth = 10,
    parameter int logT      = 9,
    parameter int T         = 512
) (
    input  logic                 CLK,
    input  logic                 iRstN,
    input  logic [17:0]          iData,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic                 iCoreDone,
    output logic [pathWidth-1:0] oSigmaWriteAddress,
    output logic [17:0]          oSigmaWriteData,
    output logic                 oSigmaWE,
    output logic [logT-1:0]      oMuWriteAddress,
    output logic [17:0]          oMuWriteData,
    output logic                 oMuWE,
    output logic                 oSwitch,
    output logic                 oStart,
    output logic [15:0]          oSwapCount
);

    typedef enum logic [2:0] {
        LOAD_SIGMA,
        LOAD_MU,
        WAIT_CORE,
        SWAP,
        START
    } state_t;

    localparam logic [pathWidth-1:0] SIG_LAST = '1;
    localparam logic [logT-1:0]      MU_LAST  = logT'(T - 1);

    state_t               r_state;
    state_t               w_next;
    logic [pathWidth-1:0] r_sig_cnt;
    logic [logT-1:0]      r_mu_cnt;
    logic                 r_running;
    logic                 r_done_seen;
    logic                 r_ready;
    logic                 r_switch;
    logic                 r_start;
    logic [15:0]          r_swap_cnt;
    logic [pathWidth-1:0] r_sig_addr;
    logic [17:0]          r_sig_data;
    logic                 r_sig_we;
    logic [logT-1:0]      r_mu_addr;
    logic [17:0]          r_mu_data;
    logic                 r_mu_we;

    logic                 w_accept;
    logic                 w_sig_acc;
    logic                 w_mu_acc;
    logic                 w_done_ok;

    // oReady is registered, so it already encodes "in a load state and out of reset".
    assign w_accept  = iValid && r_ready;
    assign w_sig_acc = w_accept && (r_state == LOAD_SIGMA);
    assign w_mu_acc  = w_accept && (r_state == LOAD_MU);
    assign w_done_ok = iCoreDone && r_running && (r_state != SWAP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD_SIGMA: if (w_sig_acc && (r_sig_cnt == SIG_LAST)) w_next = LOAD_MU;
            LOAD_MU:    if (w_mu_acc && (r_mu_cnt == MU_LAST))    w_next = WAIT_CORE;
            // A done arriving this very cycle releases the wait without a latch round-trip.
            WAIT_CORE:  if (!r_running || r_done_seen || w_done_ok) w_next = SWAP;
            SWAP:       w_next = START;
            START:      w_next = LOAD_SIGMA;
            default:    w_next = LOAD_SIGMA;
        endcase
    end

    always_ff @(posedge CLK or negedge iRstN) begin
        if (!iRstN) begin
            r_state     <= LOAD_SIGMA;
            r_sig_cnt   <= '0;
            r_mu_cnt    <= '0;
            r_running   <= 1'b0;
            r_done_seen <= 1'b0;
            r_ready     <= 1'b0;
            r_switch    <= 1'b0;
            r_start     <= 1'b0;
            r_swap_cnt  <= '0;
            r_sig_addr  <= '0;
            r_sig_data  <= '0;
            r_sig_we    <= 1'b0;
            r_mu_addr   <= '0;
            r_mu_data   <= '0;
            r_mu_we     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == LOAD_SIGMA) || (w_next == LOAD_MU);
            r_start  <= (r_state == SWAP);
            r_sig_we <= w_sig_acc;
            r_mu_we  <= w_mu_acc;

            if (w_sig_acc) begin
                r_sig_addr <= r_sig_cnt;
                r_sig_data <= iData;
                r_sig_cnt  <= (r_sig_cnt == SIG_LAST) ? '0 : r_sig_cnt + pathWidth'(1);
            end

            if (w_mu_acc) begin
                r_mu_addr <= r_mu_cnt;
                r_mu_data <= iData;
                r_mu_cnt  <= (r_mu_cnt == MU_LAST) ? '0 : r_mu_cnt + logT'(1);
            end

            if (r_state == START) begin
                r_running <= 1'b1;
            end

            if (r_state == SWAP) begin
                r_done_seen <= 1'b0;
                r_switch    <= ~r_switch;
                r_swap_cnt  <= r_swap_cnt + 16'd1;
            end else if (w_done_ok) begin
                r_done_seen <= 1'b1;
            end
        end
    end

    assign oReady             = r_ready;
    assign oSigmaWriteAddress = r_sig_addr;
    assign oSigmaWriteData    = r_sig_data;
    assign oSigmaWE           = r_sig_we;
    assign oMuWriteAddress    = r_mu_addr;
    assign oMuWriteData       = r_mu_data;
    assign oMuWE              = r_mu_we;
    assign oSwitch            = r_switch;
    assign oStart             = r_start;
    assign oSwapCount         = r_swap_cnt;

endmodule

// File: tb/tb_mc_table_loader.sv
// Bench for mc_table_loader: a table of load scenarios plus a reset-mid-load sequence.
// An event-time reference model predicts every output each cycle.
module tb_mc_table_loader;

    localparam int PW = 10;
    localparam int LT = 9;
    localparam int TT = 512;
    localparam int SD = 1 << PW;

    logic          CLK = 1'b0;
    logic          iRstN = 1'b0;
    logic [17:0]   iData = '0;
    logic          iValid = 1'b0;
    logic          iCoreDone = 1'b0;
    logic          oReady;
    logic [PW-1:0] oSigmaWriteAddress;
    logic [17:0]   oSigmaWriteData;
    logic          oSigmaWE;
    logic [LT-1:0] oMuWriteAddress;
    logic [17:0]   oMuWriteData;
    logic          oMuWE;
    logic          oSwitch;
    logic          oStart;
    logic [15:0]   oSwapCount;

    mc_table_loader #(.pathWidth(PW), .logT(LT), .T(TT)) dut (
        .CLK(CLK), .iRstN(iRstN), .iData(iData), .iValid(iValid), .oReady(oReady),
        .iCoreDone(iCoreDone),
        .oSigmaWriteAddress(oSigmaWriteAddress), .oSigmaWriteData(oSigmaWriteData), .oSigmaWE(oSigmaWE),
        .oMuWriteAddress(oMuWriteAddress), .oMuWriteData(oMuWriteData), .oMuWE(oMuWE),
        .oSwitch(oSwitch), .oStart(oStart), .oSwapCount(oSwapCount)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words are numbered within a load; the swap is scheduled as an edge number.
    int cyc = 0;
    int sent = 0;
    bit load_done = 1'b0;
    int last_acc_edge = 0;
    int m_cnt = 0;
    bit m_busy = 1'b0, m_waiting = 1'b0, m_running = 1'b0, m_done = 1'b0;
    int m_swap_edge = -100;
    int m_switch = 0, m_swcnt = 0;
    int x_ready = 0, x_swe = 0, x_mwe = 0, x_saddr = 0, x_sdata = 0, x_maddr = 0, x_mdata = 0, x_start = 0;

    always @(posedge CLK or negedge iRstN) begin
        if (!iRstN) begin
            m_cnt = 0; m_busy = 0; m_waiting = 0; m_running = 0; m_done = 0;
            m_swap_edge = -100; m_switch = 0; m_swcnt = 0;
            x_ready = 0; x_swe = 0; x_mwe = 0; x_start = 0;
        end else begin
            bit acc, done_ok;
            cyc++;
            acc = iValid && oReady;
            done_ok = iCoreDone && m_running && (cyc != m_swap_edge);
            x_swe = 0; x_mwe = 0; x_start = 0;
            if (acc) begin
                if (m_cnt < SD) begin x_swe = 1; x_saddr = m_cnt; x_sdata = int'(iData); end
                else begin x_mwe = 1; x_maddr = m_cnt - SD; x_mdata = int'(iData); end
                m_cnt++; sent++; last_acc_edge = cyc;
            end
            if (acc && m_cnt == SD + TT) begin
                m_cnt = 0; m_busy = 1; load_done = 1;
                if (!m_running || m_done || done_ok) m_swap_edge = cyc + 2;
                else m_waiting = 1;
            end else if (done_ok) begin
                if (m_waiting) begin m_swap_edge = cyc + 1; m_waiting = 0; end
                else m_done = 1;
            end
            if (cyc == m_swap_edge) begin
                m_switch ^= 1; m_swcnt = (m_swcnt + 1) % 65536; m_done = 0; x_start = 1;
            end
            if (cyc == m_swap_edge + 1) begin m_running = 1; m_busy = 0; end
            x_ready = m_busy ? 0 : 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en && iRstN) begin
            chk("ready", oReady, x_ready);
            chk("sigma_we", oSigmaWE, x_swe);
            chk("mu_we", oMuWE, x_mwe);
            chk("switch", oSwitch, m_switch);
            chk("start", oStart, x_start);
            chk("swap_count", oSwapCount, m_swcnt);
            if (x_swe != 0) begin
                chk("sigma_addr", oSigmaWriteAddress, x_saddr);
                chk("sigma_data", oSigmaWriteData, x_sdata);
            end
            if (x_mwe != 0) begin
                chk("mu_addr", oMuWriteAddress, x_maddr);
                chk("mu_data", oMuWriteData, x_mdata);
            end
        end
    end

    // mode: 0 continuous, 1 alternate valid, 2 random valid.
    // done_word: pulse done alongside this word index (-1 none); wait_d: pulse done this many cycles into the wait.
    // exp_lat: cycles from last accept edge to the start-pulse cycle (3 means no wait).
    typedef struct {
        int mode;
        int done_word;
        int wait_d;
        bit done_pre;
        int exp_lat;
        int exp_cnt;
        bit exp_sw;
    } scen_t;

    scen_t tbl[7];

    task automatic run_scen(input scen_t s, input int base, input string nm);
        int guard;
        int w;
        int lat;
        bit v;
        sent = 0; load_done = 0; guard = 0;
        @(negedge CLK);
        while (!load_done && guard < 20000) begin
            guard++;
            case (s.mode)
                0:       v = 1'b1;
                1:       v = guard[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            iValid = v;
            iData = 18'(sent + base);
            iCoreDone = (s.done_pre && guard == 1) || (v && sent == s.done_word);
            @(negedge CLK);
        end
        chk({nm, "_load_complete"}, load_done, 1);
        w = 0; lat = -1;
        while (w < 200 && lat < 0) begin
            if (oStart) lat = cyc - last_acc_edge + 1;
            else begin
                iCoreDone = (s.wait_d >= 0 && w == s.wait_d);
                iValid = 1'b1;
                iData = 18'h3FFFF;
                @(negedge CLK);
                w++;
            end
        end
        iValid = 1'b0; iCoreDone = 1'b0;
        chk({nm, "_start_latency"}, lat, s.exp_lat);
        chk({nm, "_swap_count"}, oSwapCount, s.exp_cnt);
        chk({nm, "_switch"}, oSwitch, s.exp_sw);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{mode: 0, done_word: -1,   wait_d: -1, done_pre: 1, exp_lat: 3,  exp_cnt: 1, exp_sw: 1};
        tbl[1] = '{mode: 0, done_word: -1,   wait_d: 5,  done_pre: 0, exp_lat: 8,  exp_cnt: 2, exp_sw: 0};
        tbl[2] = '{mode: 0, done_word: 500,  wait_d: -1, done_pre: 0, exp_lat: 3,  exp_cnt: 3, exp_sw: 1};
        tbl[3] = '{mode: 1, done_word: 1535, wait_d: -1, done_pre: 0, exp_lat: 3,  exp_cnt: 4, exp_sw: 0};
        tbl[4] = '{mode: 2, done_word: 1200, wait_d: -1, done_pre: 0, exp_lat: 3,  exp_cnt: 5, exp_sw: 1};
        tbl[5] = '{mode: 2, done_word: -1,   wait_d: 0,  done_pre: 0, exp_lat: 3,  exp_cnt: 6, exp_sw: 0};
        tbl[6] = '{mode: 1, done_word: -1,   wait_d: 12, done_pre: 0, exp_lat: 15, exp_cnt: 7, exp_sw: 1};

        repeat (2) @(negedge CLK);
        chk("rst_ready", oReady, 0);
        chk("rst_switch", oSwitch, 0);
        chk("rst_swap_count", oSwapCount, 0);
        chk("rst_we", {oSigmaWE, oMuWE, oStart}, 0);
        iRstN = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_scen(tbl[i], i * 2048, $sformatf("scen%0d", i));
        end

        // Reset partway through a sigma load: everything clears asynchronously, including the bank select.
        sent = 0;
        for (int i = 0; i < 2000 && sent < 300; i++) begin
            @(negedge CLK);
            iValid = 1'b1;
            iData = 18'(sent + 'h100);
        end
        chk("midload_sent", sent, 300);
        #2 iRstN = 1'b0;
        #1;
        chk("arst_ready", oReady, 0);
        chk("arst_switch", oSwitch, 0);
        chk("arst_swap_count", oSwapCount, 0);
        chk("arst_sigma_we", oSigmaWE, 0);
        chk("arst_sigma_addr", oSigmaWriteAddress, 0);
        chk("arst_sigma_data", oSigmaWriteData, 0);
        chk("arst_mu_we", oMuWE, 0);
        chk("arst_start", oStart, 0);
        iValid = 1'b0;
        repeat (3) @(negedge CLK);
        iRstN = 1'b1;
        run_scen(tbl[0], 0, "post_reset");

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
